// File: rtl/psum_pkg.sv
// Shared parameters, drain FSM encodings and the per-lane requantisation helper
// used by the psum_gbf drain path.
package psum_pkg;

    localparam int DATA_BITWIDTH      = 16;
    localparam int GBF_DATA_BITWIDTH  = 512;
    localparam int OUT_BITWIDTH       = 8;
    localparam int GBF_ADDR_BITWIDTH  = 5;
    localparam int SRAM_ADDR_BITWIDTH = 12;
    localparam int FIFO_DEPTH         = 4;

    localparam int LANES             = GBF_DATA_BITWIDTH / DATA_BITWIDTH;
    localparam int OUT_DATA_BITWIDTH = LANES * OUT_BITWIDTH;
    localparam int TILE_BITWIDTH     = SRAM_ADDR_BITWIDTH - GBF_ADDR_BITWIDTH;
    localparam int FIFO_WIDTH        = SRAM_ADDR_BITWIDTH + OUT_DATA_BITWIDTH;

    typedef enum logic [1:0] {
        DRAIN_IDLE = 2'd0,
        DRAIN_RUN  = 2'd1,
        DRAIN_DONE = 2'd2
    } drain_state_e;

    // Arithmetic shift, optional ReLU, then clamp into the signed 8-bit range.
    function automatic logic [OUT_BITWIDTH-1:0] sat_shift(
        input logic signed [DATA_BITWIDTH-1:0] lane,
        input logic        [3:0]               shift,
        input logic                            relu_en
    );
        logic signed [DATA_BITWIDTH-1:0] v;
        logic        [OUT_BITWIDTH-1:0]  res;
        v = lane >>> shift;
        if (relu_en && (v < 16'sd0)) begin
            v = 16'sd0;
        end else begin
            v = v;
        end
        if (v > 16'sd127) begin
            res = 8'h7F;
        end else if (v < -16'sd128) begin
            res = 8'h80;
        end else begin
            res = v[OUT_BITWIDTH-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/psum_gbf_drain_if.sv
// Valid/ready stream from the drain FIFO head to the output-activation SRAM writer.
interface psum_gbf_drain_if;
    import psum_pkg::*;

    logic                          out_valid;
    logic                          out_ready;
    logic [SRAM_ADDR_BITWIDTH-1:0] out_addr;
    logic [OUT_DATA_BITWIDTH-1:0]  out_data;

    modport master (output out_valid, output out_addr, output out_data, input out_ready);
    modport slave  (input out_valid, input out_addr, input out_data, output out_ready);

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous flush; a pop frees its slot for a push in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] PTR_ONE   = PW'(1);
    localparam logic [PW:0]   CNT_ONE   = (PW + 1)'(1);
    localparam logic [PW:0]   CNT_DEPTH = (PW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [PW:0]      count_r;
    logic             do_pop_s;
    logic             do_push_s;

    assign do_pop_s  = pop && (count_r != '0);
    assign do_push_s = push && ((count_r != CNT_DEPTH) || do_pop_s);

    assign pop_data = mem_r[rd_ptr_r];
    assign full     = (count_r == CNT_DEPTH);
    assign empty    = (count_r == '0);
    assign count    = count_r;

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_r    <= '{default: '0};
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else if (flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/psum_gbf_drain.sv
// Captures psum_gbf rows during the su_adder drain, requantises each lane and queues
// the packed rows for the output-activation SRAM writer.
module psum_gbf_drain
    import psum_pkg::*;
(
    input  logic                          clk,
    input  logic                          reset,
    input  logic [SRAM_ADDR_BITWIDTH-1:0] cfg_base_addr,
    input  logic [3:0]                    cfg_shift,
    input  logic                          cfg_relu_en,
    input  logic                          start,
    input  logic                          gbf_r_en,
    input  logic [GBF_ADDR_BITWIDTH-1:0]  gbf_r_addr,
    input  logic [GBF_DATA_BITWIDTH-1:0]  gbf_r_data,
    input  logic                          conv_finish,
    psum_gbf_drain_if.master              out_if,
    output logic                          tile_done,
    output logic                          conv_done,
    output logic                          overflow
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [TILE_BITWIDTH-1:0] TILE_ONE = TILE_BITWIDTH'(1);

    drain_state_e                  state_r;
    logic [SRAM_ADDR_BITWIDTH-1:0] cfg_base_r;
    logic [3:0]                    cfg_shift_r;
    logic                          cfg_relu_r;
    logic                          armed_r;
    logic [GBF_ADDR_BITWIDTH-1:0]  last_addr_r;
    logic                          cap_valid_r;
    logic [GBF_ADDR_BITWIDTH-1:0]  cap_addr_r;
    logic                          p1_valid_r;
    logic [GBF_ADDR_BITWIDTH-1:0]  p1_addr_r;
    logic [GBF_DATA_BITWIDTH-1:0]  p1_data_r;
    logic [TILE_BITWIDTH-1:0]      tile_cnt_r;
    logic                          tile_done_r;
    logic                          conv_done_r;
    logic                          overflow_r;

    logic                          cap_s;
    logic                          row_last_s;
    logic                          pop_s;
    logic                          push_s;
    logic                          drop_s;
    logic [SRAM_ADDR_BITWIDTH-1:0] p2_addr_s;
    logic [OUT_DATA_BITWIDTH-1:0]  p2_data_s;
    logic [FIFO_WIDTH-1:0]         fifo_rdata_s;
    logic                          fifo_full_s;
    logic                          fifo_empty_s;
    logic [CNT_W-1:0]              fifo_count_s;

    // A held address shows up twice; only a change (or the first read after re-arm) is a new row.
    assign cap_s      = (state_r == DRAIN_RUN) && gbf_r_en && (!armed_r || (gbf_r_addr != last_addr_r));
    assign row_last_s = p1_valid_r && (p1_addr_r == {GBF_ADDR_BITWIDTH{1'b1}});
    assign pop_s      = out_if.out_valid && out_if.out_ready;
    assign push_s     = p1_valid_r && (!fifo_full_s || pop_s);
    assign drop_s     = p1_valid_r && !push_s;
    assign p2_addr_s  = cfg_base_r + {tile_cnt_r, p1_addr_r};

    // P2: per-lane shift / ReLU / saturate of the registered row.
    always_comb begin
        p2_data_s = '0;
        for (int i = 0; i < LANES; i++) begin
            p2_data_s[i*OUT_BITWIDTH +: OUT_BITWIDTH] =
                sat_shift($signed(p1_data_r[i*DATA_BITWIDTH +: DATA_BITWIDTH]), cfg_shift_r, cfg_relu_r);
        end
    end

    sync_fifo #(
        .WIDTH (FIFO_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (start),
        .push      (push_s),
        .push_data ({p2_addr_s, p2_data_s}),
        .pop       (pop_s),
        .pop_data  (fifo_rdata_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .count     (fifo_count_s)
    );

    assign out_if.out_valid = !fifo_empty_s;
    assign out_if.out_addr  = fifo_rdata_s[FIFO_WIDTH-1 -: SRAM_ADDR_BITWIDTH];
    assign out_if.out_data  = fifo_rdata_s[OUT_DATA_BITWIDTH-1:0];
    assign tile_done        = tile_done_r;
    assign conv_done        = conv_done_r;
    assign overflow         = overflow_r;

    // Drain FSM, dedupe tracking, P1 pipeline, tile counter and status flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= DRAIN_IDLE;
            cfg_base_r  <= '0;
            cfg_shift_r <= 4'd0;
            cfg_relu_r  <= 1'b0;
            armed_r     <= 1'b0;
            last_addr_r <= '0;
            cap_valid_r <= 1'b0;
            cap_addr_r  <= '0;
            p1_valid_r  <= 1'b0;
            p1_addr_r   <= '0;
            p1_data_r   <= '0;
            tile_cnt_r  <= '0;
            tile_done_r <= 1'b0;
            conv_done_r <= 1'b0;
            overflow_r  <= 1'b0;
        end else if (start) begin
            state_r     <= DRAIN_RUN;
            cfg_base_r  <= cfg_base_addr;
            cfg_shift_r <= cfg_shift;
            cfg_relu_r  <= cfg_relu_en;
            armed_r     <= 1'b0;
            cap_valid_r <= 1'b0;
            p1_valid_r  <= 1'b0;
            tile_cnt_r  <= '0;
            tile_done_r <= 1'b0;
            conv_done_r <= 1'b0;
            overflow_r  <= 1'b0;
        end else begin
            cap_valid_r <= cap_s;
            p1_valid_r  <= cap_valid_r;
            tile_done_r <= 1'b0;
            if (cap_s) begin
                cap_addr_r  <= gbf_r_addr;
                last_addr_r <= gbf_r_addr;
                armed_r     <= 1'b1;
            end else if (row_last_s) begin
                armed_r     <= 1'b0;
            end
            if (cap_valid_r) begin
                p1_addr_r <= cap_addr_r;
                p1_data_r <= gbf_r_data;
            end
            // A dropped last row still closes the tile so later addresses stay aligned.
            if (row_last_s) begin
                tile_cnt_r  <= tile_cnt_r + TILE_ONE;
                tile_done_r <= push_s;
            end
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
            case (state_r)
                DRAIN_RUN: begin
                    if (conv_finish && (fifo_count_s == '0) && !cap_valid_r && !p1_valid_r) begin
                        state_r     <= DRAIN_DONE;
                        conv_done_r <= 1'b1;
                    end
                end
                DRAIN_IDLE: state_r <= DRAIN_IDLE;
                DRAIN_DONE: state_r <= DRAIN_DONE;
                default:    state_r <= DRAIN_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_psum_gbf_drain.sv
// Directed scoreboard bench for psum_gbf_drain: stimulus queues expected rows, a negedge
// monitor pops and compares every accepted FIFO head.
module tb_psum_gbf_drain;
    import psum_pkg::*;

    typedef struct packed {
        logic [11:0]  addr;
        logic [255:0] data;
    } exp_t;

    logic         clk;
    logic         reset;
    logic [11:0]  cfg_base_addr;
    logic [3:0]   cfg_shift;
    logic         cfg_relu_en;
    logic         start;
    logic         gbf_r_en;
    logic [4:0]   gbf_r_addr;
    logic [511:0] gbf_r_data;
    logic         conv_finish;
    logic         tile_done;
    logic         conv_done;
    logic         overflow;

    psum_gbf_drain_if oif ();

    psum_gbf_drain dut (
        .clk           (clk),
        .reset         (reset),
        .cfg_base_addr (cfg_base_addr),
        .cfg_shift     (cfg_shift),
        .cfg_relu_en   (cfg_relu_en),
        .start         (start),
        .gbf_r_en      (gbf_r_en),
        .gbf_r_addr    (gbf_r_addr),
        .gbf_r_data    (gbf_r_data),
        .conv_finish   (conv_finish),
        .out_if        (oif),
        .tile_done     (tile_done),
        .conv_done     (conv_done),
        .overflow      (overflow)
    );

    int   total = 0;
    int   bad = 0;
    int   pops = 0;
    int   tile_pulses = 0;
    exp_t exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    function automatic logic [511:0] mk_row(input int a);
        logic [511:0] r;
        for (int i = 0; i < 32; i++) r[i*16 +: 16] = 16'(a + i);
        return r;
    endfunction

    function automatic logic [255:0] exp_bytes(input int a);
        logic [255:0] b;
        for (int i = 0; i < 32; i++) b[i*8 +: 8] = 8'(a + i);
        return b;
    endfunction

    task automatic expect_row(input logic [11:0] addr, input logic [255:0] data);
        exp_t e;
        e.addr = addr;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // su_adder style: address held two cycles, data valid in the second one.
    task automatic issue_row(input logic [4:0] a, input logic [511:0] d);
        gbf_r_en = 1'b1;
        gbf_r_addr = a;
        @(posedge clk); #1;
        gbf_r_data = d;
        @(posedge clk); #1;
    endtask

    task automatic do_start(input logic [11:0] base, input logic [3:0] sh, input logic relu);
        cfg_base_addr = base;
        cfg_shift = sh;
        cfg_relu_en = relu;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_drain(input int budget, input string nm);
        for (int k = 0; k < budget && exp_q.size() != 0; k++) @(posedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s pending=%0d want=0", nm, exp_q.size());
        end
        #1;
    endtask

    // Monitor: every accepted head is checked against the oldest expected row.
    always @(negedge clk) begin
        if (!reset) begin
            if (tile_done) tile_pulses++;
            if (oif.out_valid && oif.out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_pop got_addr=%h want=none", oif.out_addr);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("pop_addr", 256'(oif.out_addr), 256'(e.addr));
                    chk("pop_data", oif.out_data, e.data);
                    pops++;
                end
            end
        end
    end

    initial begin
        int p0;
        logic [11:0] ea;
        reset = 1'b1; start = 1'b0; cfg_base_addr = '0; cfg_shift = '0; cfg_relu_en = 1'b0;
        gbf_r_en = 1'b0; gbf_r_addr = '0; gbf_r_data = '0; conv_finish = 1'b0; oif.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        chk("rst_out_valid", 256'(oif.out_valid), 256'd0);
        chk("rst_out_addr", 256'(oif.out_addr), 256'd0);
        chk("rst_out_data", oif.out_data, 256'd0);
        chk("rst_tile_done", 256'(tile_done), 256'd0);
        chk("rst_conv_done", 256'(conv_done), 256'd0);
        chk("rst_overflow", 256'(overflow), 256'd0);

        // 1: one full tile, free-flowing output
        oif.out_ready = 1'b1;
        do_start(12'h100, 4'd0, 1'b0);
        tile_pulses = 0; p0 = pops;
        for (int a = 0; a < 32; a++) begin
            expect_row(12'h100 + 12'(a), exp_bytes(a));
            issue_row(5'(a), mk_row(a));
        end
        gbf_r_en = 1'b0;
        wait_drain(60, "t1_drain");
        chk("t1_pop_count", 256'(pops - p0), 256'd32);
        chk("t1_tile_done", 256'(tile_pulses), 256'd1);
        chk("t1_overflow", 256'(overflow), 256'd0);

        // 2: shift/saturate, then ReLU; second start must re-arm address 0
        do_start(12'h040, 4'd4, 1'b0);
        expect_row(12'h040, {8{32'hFF05807F}});
        issue_row(5'd0, {8{64'hFFF0_0050_8000_7FFF}});
        gbf_r_en = 1'b0;
        wait_drain(20, "t2_noralu_drain");
        do_start(12'h040, 4'd4, 1'b1);
        expect_row(12'h040, {8{32'h0005007F}});
        issue_row(5'd0, {8{64'hFFF0_0050_8000_7FFF}});
        gbf_r_en = 1'b0;
        wait_drain(20, "t2_relu_drain");

        // 3: stalled sink -> 4 rows kept, rest dropped
        oif.out_ready = 1'b0;
        do_start(12'h200, 4'd0, 1'b0);
        p0 = pops;
        for (int a = 0; a < 32; a++) begin
            if (a < 4) expect_row(12'h200 + 12'(a), exp_bytes(a));
            issue_row(5'(a), mk_row(a));
        end
        gbf_r_en = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("t3_overflow", 256'(overflow), 256'd1);
        chk("t3_head_valid", 256'(oif.out_valid), 256'd1);
        chk("t3_head_addr_a", 256'(oif.out_addr), 256'h200);
        chk("t3_head_data_a", oif.out_data, exp_bytes(0));
        repeat (5) @(posedge clk);
        #1;
        chk("t3_head_addr_b", 256'(oif.out_addr), 256'h200);
        chk("t3_head_data_b", oif.out_data, exp_bytes(0));
        oif.out_ready = 1'b1;
        wait_drain(20, "t3_drain");
        chk("t3_pop_count", 256'(pops - p0), 256'd4);
        chk("t3_empty", 256'(oif.out_valid), 256'd0);

        // 4: two tiles, base wraps the 12-bit address space
        do_start(12'hFF0, 4'd0, 1'b0);
        chk("t4_overflow_cleared", 256'(overflow), 256'd0);
        tile_pulses = 0; p0 = pops;
        for (int t = 0; t < 2; t++) begin
            for (int a = 0; a < 32; a++) begin
                ea = 12'hFF0 + 12'(t * 32 + a);
                expect_row(ea, exp_bytes(a));
                issue_row(5'(a), mk_row(a));
            end
        end
        gbf_r_en = 1'b0;
        wait_drain(60, "t4_drain");
        chk("t4_pop_count", 256'(pops - p0), 256'd64);
        chk("t4_tile_done", 256'(tile_pulses), 256'd2);

        // 5: conv_finish with rows in flight
        oif.out_ready = 1'b0;
        do_start(12'h300, 4'd0, 1'b0);
        expect_row(12'h300, exp_bytes(0));
        expect_row(12'h301, exp_bytes(1));
        issue_row(5'd0, mk_row(0));
        issue_row(5'd1, mk_row(1));
        gbf_r_en = 1'b0;
        conv_finish = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("t5_conv_done_held", 256'(conv_done), 256'd0);
        oif.out_ready = 1'b1;
        wait_drain(20, "t5_drain");
        chk("t5_conv_done_at_pop", 256'(conv_done), 256'd0);
        @(posedge clk); #1;
        chk("t5_conv_done_set", 256'(conv_done), 256'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("t5_conv_done_level", 256'(conv_done), 256'd1);
        conv_finish = 1'b0;
        do_start(12'h400, 4'd0, 1'b0);
        chk("t5_conv_done_cleared", 256'(conv_done), 256'd0);

        // 6: async reset with three rows queued
        oif.out_ready = 1'b0;
        issue_row(5'd0, mk_row(0));
        issue_row(5'd1, mk_row(1));
        issue_row(5'd2, mk_row(2));
        gbf_r_en = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("t6_pre_valid", 256'(oif.out_valid), 256'd1);
        reset = 1'b1;
        #1;
        chk("t6_reset_valid", 256'(oif.out_valid), 256'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        oif.out_ready = 1'b1;
        do_start(12'h400, 4'd0, 1'b0);
        expect_row(12'h400, exp_bytes(0));
        issue_row(5'd0, mk_row(0));
        gbf_r_en = 1'b0;
        wait_drain(20, "t6_recapture");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
